// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   - default widths and the zero-register option
//   - well-known register indices (REG_ZERO and REG_RA)
//   - a helper function that returns the low bit of port slot i in a flattened port bus
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_ZERO_REG = 1;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    // Returns the low bit of slot `port` in a bus made of `width`-bit slots.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard.
// An issued producer marks its destination pending. A write to a register clears
// that register's bit. If a set and a clear hit the same register in one cycle,
// the set wins, because the newer producer is still outstanding. A flush clears
// every bit and also cancels an issue in the same cycle.
//   clk        : clock
//   reset      : asynchronous active-high reset, clears every bit
//   issue_en_i : set the pending bit of issue_adr_i
//   issue_adr_i: register to mark pending
//   clr_en_i   : per-write-port clear enables
//   clr_adr_i  : per-write-port clear addresses, port j at [j*ADDR_W +: ADDR_W]
//   flush_i    : synchronous clear of all bits
//   pending_o  : current pending vector, one bit per register
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NW       = 1,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_en_i,
    input  logic [ADDR_W-1:0]    issue_adr_i,
    input  logic [NW-1:0]        clr_en_i,
    input  logic [NW*ADDR_W-1:0] clr_adr_i,
    input  logic                 flush_i,
    output logic [DEPTH-1:0]     pending_o
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        // Register 0 is hardwired when ZERO_REG is set, so it never becomes pending.
        if (issue_en_i && !(ZERO_REG != 0 && issue_adr_i == '0)) begin
            set_vec[issue_adr_i] = 1'b1;
        end
        for (int j = 0; j < NW; j++) begin
            if (clr_en_i[j]) begin
                clr_vec[clr_adr_i[slice_lo(j, ADDR_W) +: ADDR_W]] = 1'b1;
            end
        end
        // OR in the set after the clear, so the set wins on the same register.
        pending_d = flush_i ? '0 : (set_vec | (pending_q & ~clr_vec));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through forwarding and a pending scoreboard.
// Reads are combinational. For each read port, register 0 reads as 0 when ZERO_REG
// is set. Otherwise a same-cycle write to the read address is forwarded, and the
// highest-numbered write port wins. Otherwise the stored value is returned.
//   clk        : clock
//   reset      : asynchronous active-high reset, clears storage and pending bits
//   rd_adr     : read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    : read data, port i at [i*DATA_W +: DATA_W]
//   rd_pending : pending flag of the register addressed by each read port
//   wr_en      : write enables, one per write port
//   wr_adr     : write addresses
//   wr_data    : write data
//   issue_en   : mark issue_adr pending from the next cycle
//   issue_adr  : destination register of the issued instruction
//   flush      : clear all pending bits at the next edge
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NR*ADDR_W-1:0] rd_adr,
    output logic [NR*DATA_W-1:0] rd_data,
    output logic [NR-1:0]        rd_pending,
    input  logic [NW-1:0]        wr_en,
    input  logic [NW*ADDR_W-1:0] wr_adr,
    input  logic [NW*DATA_W-1:0] wr_data,
    input  logic                 issue_en,
    input  logic [ADDR_W-1:0]    issue_adr,
    input  logic                 flush
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pending;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NW       (NW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_en_i  (issue_en),
        .issue_adr_i (issue_adr),
        .clr_en_i    (wr_en),
        .clr_adr_i   (wr_adr),
        .flush_i     (flush),
        .pending_o   (pending)
    );

    // Apply the write ports in ascending order so the higher port wins a shared address.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NW; j++) begin
            if (wr_en[j] &&
                !(ZERO_REG != 0 && wr_adr[slice_lo(j, ADDR_W) +: ADDR_W] == '0)) begin
                mem_d[wr_adr[slice_lo(j, ADDR_W) +: ADDR_W]] =
                    wr_data[slice_lo(j, DATA_W) +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [ADDR_W-1:0] rd_a;
        logic [DATA_W-1:0] rd_d;
        logic              fwd_hit;
        logic              issue_hit;

        assign rd_a      = rd_adr[slice_lo(i, ADDR_W) +: ADDR_W];
        assign issue_hit = issue_en && (issue_adr == rd_a);

        always_comb begin
            rd_d    = mem_q[rd_a];
            fwd_hit = 1'b0;
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j] && wr_adr[slice_lo(j, ADDR_W) +: ADDR_W] == rd_a) begin
                    rd_d    = wr_data[slice_lo(j, DATA_W) +: DATA_W];
                    fwd_hit = 1'b1;
                end
            end
            if (ZERO_REG != 0 && rd_a == '0) begin
                rd_d = '0;
            end
        end

        assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = rd_d;
        // A forwarded write already delivers the value. The pending flag drops,
        // unless a new producer is being issued to the same register this cycle.
        assign rd_pending[i] = pending[rd_a] & ~(fwd_hit & ~issue_hit);
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with write-through forwarding and a per-register pending scoreboard. It is the next-generation replacement for the single-write, dual-read datapath register file. It sits between decode (read ports, issue) and writeback (write ports) of the MIPS pipeline. Its scoreboard lets the hazard unit stall on registers whose producer has not yet written back.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), register address width
- NR, 2, number of read ports (1..4)
- NW, 1, number of write ports (1..2)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never pending

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and all pending bits
- rd_adr  in  NR*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NR*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_pending  out  NR  pending bit of register addressed by read port i
- wr_en  in  NW  write enables
- wr_adr  in  NW*ADDR_W  write addresses
- wr_data  in  NW*DATA_W  write data
- issue_en  in  1  mark issue_adr pending (new in-flight producer)
- issue_adr  in  ADDR_W  destination register of issued instruction
- flush  in  1  synchronous clear of all pending bits (pipeline flush)

## Operation
- Storage: DEPTH x DATA_W flops, asynchronously cleared to 0 on reset.
- Reads are combinational, with rd_data[i] resolved in this order:
  - ZERO_REG && rd_adr==0: read 0.
  - Else, a same-cycle write with wr_en[j] && wr_adr[j]==rd_adr[i]: forward wr_data[j]. The highest j wins.
  - Else, the stored value.
- Writes: at posedge, registers[wr_adr[j]] <= wr_data[j] for each enabled j. Two ports writing the same address: the higher index wins. Writes to register 0 are dropped when ZERO_REG=1.
- Scoreboard, one bit per register:
  - Set: issue_en at posedge sets pending[issue_adr].
  - Clear: any enabled write port clears pending[wr_adr[j]].
  - Simultaneous set and clear of the same address: set wins, because the newer producer is outstanding.
  - flush clears all bits and overrides issue_en in the same cycle.
  - Register 0 is never set when ZERO_REG=1.
- rd_pending[i] is combinational from the current pending bits. It is deasserted when a same-cycle write to that address forwards its data and no same-cycle issue targets it.
- No handshake: every write and issue is accepted. Writes to non-pending registers are legal.

## Timing
- Read latency 0 cycles: rd_data and rd_pending are combinational from rd_adr, the write ports and state.
- Write latency: visible the same cycle through forwarding, and from storage the next cycle.
- Issue sets the pending bit from the next cycle; rd_pending rises one cycle after issue_en.
- Reset mid-operation: all state is cleared immediately, without waiting for a clock edge. While reset is high, rd_data shows forwarded write data or 0, and rd_pending follows the forwarding rule only. The first edge after reset deassertion may write.
- Reset values:
  - rd_data = 0 (absent forwarding).
  - rd_pending = 0.

## Structure
- Shared package regfile_pkg holds:
  - default DATA_W, DEPTH and ZERO_REG
  - register index constants (REG_ZERO, REG_RA = 31)
  - the port-slice helper functions
- The scoreboard is natural as sub-module regfile_scoreboard:
  - inputs: clk, reset, issue, clear ports, flush
  - output: DEPTH-bit pending vector
- Forwarding muxes and storage stay in regfile_mp.

## Test plan
- Reset then read: assert reset with registers previously written. Required: all rd_data = 0 and rd_pending = 0 with no clock edge, and register 5 reads 0 after deassertion.
- Write and forward: wr_en=1, wr_adr=7, wr_data=0xDEADBEEF, rd_adr[0]=7 in the same cycle. Required: rd_data[0]=0xDEADBEEF that cycle, and it holds from storage next cycle with wr_en=0.
- Register zero: write 0x12345678 to address 0, then issue_en to address 0. Required: reads of address 0 return 0 in both cycles, and rd_pending stays 0.
- Write-port conflict (NW=2): both ports write address 3, port0=0x1 and port1=0x2. Required: forwarded read = 0x2, and the stored value = 0x2.
- Scoreboard flow: issue address 9, then wait 3 cycles. Required: rd_pending=1 from cycle +1. Then write address 9. Required: rd_pending=0 that cycle with data forwarded.
- Simultaneous events:
  - issue and write address 4 in the same cycle. Required: pending[4]=1 afterwards.
  - flush together with issue address 6. Required: all pending bits are 0 afterwards.
